ex_mem_stage: RTL and testbench

- Parametrised EX/MEM pipeline register; successor of the fixed-width EX/MEM latch.
- Carries register-write, HI/LO-write, load/store and ALU-op fields from EX to MEM.
- Adds stall-chain bubble insertion, flush, and a valid bit.
- Adds a feedback path holding the multicycle (madd/msub-style) partial-product and cycle count while EX is stalled.
- Adds a saturating bubble-cycle performance counter.

---
 rtl/ex_mem_stage.sv | 140 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall-chain bubble insertion, flush, a valid bit,
// multicycle partial-product feedback to EX and a saturating bubble counter.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   ex_hilo_tmp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_tmp_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [PERF_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_FLUSH  = 2'd1,
    UPD_BUBBLE = 2'd2,
    UPD_LOAD   = 2'd3
  } upd_e;

  upd_e upd_s;

  // Select the single update applied this cycle; a stalled MEM always wins over EX,
  // so the illegal EX-running/MEM-stalled combination simply holds.
  always_comb begin
    upd_s = UPD_HOLD;
    if (flush) begin
      upd_s = UPD_FLUSH;
    end else if (stall_mem) begin
      upd_s = UPD_HOLD;
    end else if (stall_ex) begin
      upd_s = UPD_BUBBLE;
    end else begin
      upd_s = UPD_LOAD;
    end
  end

  // Pipeline register, feedback path and bubble counter, all updated atomically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid    <= 1'b0;
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_whilo    <= 1'b0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_tmp_o   <= '0;
      cnt_o        <= '0;
      bubble_cnt   <= '0;
    end else begin
      case (upd_s)
        UPD_FLUSH: begin
          mem_valid    <= 1'b0;
          mem_wd       <= '0;
          mem_wreg     <= 1'b0;
          mem_wdata    <= '0;
          mem_whilo    <= 1'b0;
          mem_hi       <= '0;
          mem_lo       <= '0;
          mem_aluop    <= '0;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
          hilo_tmp_o   <= '0;
          cnt_o        <= '0;
        end
        UPD_BUBBLE: begin
          mem_valid    <= 1'b0;
          mem_wd       <= '0;
          mem_wreg     <= 1'b0;
          mem_wdata    <= '0;
          mem_whilo    <= 1'b0;
          mem_hi       <= '0;
          mem_lo       <= '0;
          mem_aluop    <= '0;
          mem_mem_addr <= '0;
          mem_reg2     <= '0;
          // EX keeps iterating the multicycle op while the bubble goes downstream
          hilo_tmp_o   <= ex_hilo_tmp;
          cnt_o        <= ex_cnt;
          if (bubble_cnt != {PERF_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + PERF_W'(1);
          end else begin
            bubble_cnt <= bubble_cnt;
          end
        end
        UPD_LOAD: begin
          mem_valid    <= ex_valid;
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_wdata    <= ex_wdata;
          mem_whilo    <= ex_whilo;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
          hilo_tmp_o   <= '0;
          cnt_o        <= '0;
        end
        default: begin
          mem_valid    <= mem_valid;
          bubble_cnt   <= bubble_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a driver pushes model-predicted outputs per edge,
// an independent monitor pops and compares them just after each rising edge.
module tb_ex_mem_stage;

  localparam int PERF_W  = 4;
  localparam int BUB_MAX = (1 << PERF_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [3:0]  bub;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ex, stall_mem, flush;
  logic        ex_valid, ex_wreg, ex_whilo;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] ex_hilo_tmp;
  logic [1:0]  ex_cnt;
  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;
  logic [3:0]  bubble_cnt;

  out_t mdl;
  out_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(8), .CNT_W(2), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_tmp_o(hilo_tmp_o),
    .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
  );

  function automatic out_t dut_out();
    out_t o;
    o.valid = mem_valid;   o.wd = mem_wd;         o.wreg = mem_wreg;
    o.wdata = mem_wdata;   o.whilo = mem_whilo;   o.hi = mem_hi;
    o.lo = mem_lo;         o.aluop = mem_aluop;   o.addr = mem_mem_addr;
    o.reg2 = mem_reg2;     o.hilo = hilo_tmp_o;   o.cnt = cnt_o;
    o.bub = bubble_cnt;
    return o;
  endfunction

  task automatic cmp(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Reference behaviour: what the MEM side should hold after one edge with the current inputs.
  task automatic step();
    out_t n;
    n = mdl;
    if (!rst) begin
      n = '0;
    end else if (flush || (stall_ex && !stall_mem)) begin
      n = '0;
      n.bub = mdl.bub;
      if (!flush) begin
        n.hilo = ex_hilo_tmp;
        n.cnt  = ex_cnt;
        n.bub  = (int'(mdl.bub) + 1 > BUB_MAX) ? mdl.bub : 4'(int'(mdl.bub) + 1);
      end
    end else if (!stall_mem) begin
      n.valid = ex_valid;  n.wd = ex_wd;       n.wreg = ex_wreg;
      n.wdata = ex_wdata;  n.whilo = ex_whilo; n.hi = ex_hi;
      n.lo = ex_lo;        n.aluop = ex_aluop; n.addr = ex_mem_addr;
      n.reg2 = ex_reg2;    n.hilo = 64'd0;     n.cnt = 2'd0;
    end
    mdl = n;
    sbq.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_ex();
    ex_valid    = 1'($urandom);
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_whilo    = 1'($urandom);
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_aluop    = 8'($urandom);
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    ex_hilo_tmp = {$urandom, $urandom};
    ex_cnt      = 2'($urandom);
  endtask

  // Monitor: the DUT presents a new output set after every rising edge.
  always @(posedge clk) begin
    out_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("sb", dut_out(), e);
    end
  end

  initial begin
    rst = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0; flush = 1'b0;
    rand_ex();
    mdl = '0;
    @(negedge clk);
    cmp("reset_state", dut_out(), '0);
    rst = 1'b1;

    // pass-through
    rand_ex();
    ex_valid = 1'b1; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
    ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
    step();

    // multicycle stall then release
    rand_ex();
    stall_ex = 1'b1; ex_cnt = 2'd1; ex_hilo_tmp = 64'h0000_0001_FFFF_FFFF;
    step();
    stall_ex = 1'b0;
    rand_ex();
    step();

    // hold while EX toggles
    stall_ex = 1'b1; stall_mem = 1'b1;
    repeat (3) begin rand_ex(); step(); end
    // illegal EX-run / MEM-stall combination also holds
    stall_ex = 1'b0;
    rand_ex(); step();
    stall_mem = 1'b0;

    // flush beats stall
    flush = 1'b1; stall_ex = 1'b1;
    rand_ex(); step();
    flush = 1'b0; stall_ex = 1'b0;

    // asynchronous reset mid-operation
    rand_ex();
    ex_valid = 1'b1; ex_wdata = 32'h1234_5678;
    step();
    #2 rst = 1'b0;
    #1 cmp("async_reset", dut_out(), '0);
    mdl = '0;
    @(negedge clk);
    rand_ex(); step();
    rst = 1'b1;
    rand_ex(); ex_valid = 1'b1;
    step();

    // saturation of the bubble counter
    stall_ex = 1'b1;
    repeat (20) begin rand_ex(); step(); end
    n_cmp++;
    if (bubble_cnt !== 4'hF) begin
      n_fail++;
      $display("FAIL bubble_sat: got %h expected %h", bubble_cnt, 4'hF);
    end
    stall_ex = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_ex();
      flush     = ($urandom_range(0, 9) == 0);
      stall_mem = ($urandom_range(0, 3) == 0);
      stall_ex  = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 59) != 0);
      step();
    end
    rst = 1'b1;
    step();

    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected %0d", sbq.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
